wb_pipe_stage: RTL and testbench

Parametrised MEM/WB pipeline stage for the CPU datapath. It carries write-back control (RegWrite, MemtoReg), memory read data, the ALU result and the destination register address from MEM to WB. Compared with a plain hold-on-stall register, it adds:
- a valid/ready handshake with a 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready;
- a flush input;
- zero-register write suppression;
- a muxed write-back data output.

---
 rtl/wb_pipe_if.sv | 41 ++++
 rtl/wb_pipe_stage.sv | 93 +++++++++
 tb/tb_wb_pipe_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wb_pipe_if.sv
// MEM/WB stage bundle: upstream entry, downstream handshake,
// flush/stall controls and write-back outputs in one interface.
interface wb_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              flush_i;
    logic              stall_i;
    logic              valid_i;
    logic              ready_o;
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic [DATA_W-1:0] dataMem_data_i;
    logic [DATA_W-1:0] ALU_result_i;
    logic [REG_AW-1:0] RDaddr_i;
    logic              valid_o;
    logic              ready_i;
    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic [DATA_W-1:0] dataMem_data_o;
    logic [DATA_W-1:0] ALU_result_o;
    logic [REG_AW-1:0] RDaddr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [1:0]        count_o;

    modport slave (
        input  flush_i, stall_i, valid_i, RegWrite_i, MemtoReg_i,
        input  dataMem_data_i, ALU_result_i, RDaddr_i, ready_i,
        output ready_o, valid_o, RegWrite_o, MemtoReg_o,
        output dataMem_data_o, ALU_result_o, RDaddr_o, wb_data_o,
        output count_o
    );

    modport master (
        output flush_i, stall_i, valid_i, RegWrite_i, MemtoReg_i,
        output dataMem_data_i, ALU_result_i, RDaddr_i, ready_i,
        input  ready_o, valid_o, RegWrite_o, MemtoReg_o,
        input  dataMem_data_o, ALU_result_o, RDaddr_o, wb_data_o,
        input  count_o
    );
endinterface

// File: rtl/wb_pipe_stage.sv
// MEM/WB pipeline stage with a 2-entry skid buffer, flush,
// zero-register write suppression and muxed write-back data.
module wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_pipe_if.slave    bus
);
    typedef struct packed {
        logic              rw;
        logic              m2r;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [REG_AW-1:0] rd;
    } ent_t;

    ent_t main_q, main_d;
    ent_t skid_q, skid_d;
    logic main_v_q, main_v_d;
    logic skid_v_q, skid_v_d;
    ent_t in_ent;
    logic accept;
    logic drain;

    // Incoming entry; writes to x0 are killed at capture.
    always_comb begin
        in_ent     = '0;
        in_ent.rw  = bus.RegWrite_i & (bus.RDaddr_i != '0);
        in_ent.m2r = bus.MemtoReg_i;
        in_ent.mem = bus.dataMem_data_i;
        in_ent.alu = bus.ALU_result_i;
        in_ent.rd  = bus.RDaddr_i;
    end

    assign accept = bus.valid_i & ~skid_v_q & ~bus.flush_i;
    assign drain  = main_v_q & bus.ready_i & ~bus.stall_i;

    // Next-state for main/skid entries; skid feeds main in order.
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (bus.flush_i) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (accept) begin
                main_d   = in_ent;
                main_v_d = 1'b1;
            end
        end else if (!skid_v_q) begin
            if (drain && accept) begin
                main_d = in_ent;
            end else if (drain) begin
                main_v_d = 1'b0;
            end else if (accept) begin
                skid_d   = in_ent;
                skid_v_d = 1'b1;
            end
        end else if (drain) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign bus.valid_o        = main_v_q;
    assign bus.ready_o        = ~skid_v_q;
    assign bus.RegWrite_o     = main_v_q & main_q.rw;
    assign bus.MemtoReg_o     = main_q.m2r;
    assign bus.dataMem_data_o = main_q.mem;
    assign bus.ALU_result_o   = main_q.alu;
    assign bus.RDaddr_o       = main_q.rd;
    assign bus.wb_data_o      = main_q.m2r ? main_q.mem : main_q.alu;
    assign bus.count_o        = {1'b0, main_v_q} + {1'b0, skid_v_q};
endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage with a queue model of the
// entries held in the stage, checked every cycle.
module tb_wb_pipe_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wb_pipe_if #(.DATA_W(32), .REG_AW(5)) bus ();

    wb_pipe_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  rd;
    } ent_t;

    ent_t held[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rd);
        bus.valid_i        = v;
        bus.RegWrite_i     = rw;
        bus.MemtoReg_i     = m2r;
        bus.dataMem_data_i = mem;
        bus.ALU_result_i   = alu;
        bus.RDaddr_i       = rd;
    endtask

    // One clock: check outputs against model, step, update model.
    task automatic cyc(output bit acc);
        bit   ev, er, drn, fl;
        ent_t h;
        ent_t inp;
        ev = held.size() > 0;
        er = held.size() < 2;
        chk("valid_o", bus.valid_o, ev);
        chk("ready_o", bus.ready_o, er);
        chk("count_o", bus.count_o, held.size());
        if (ev) begin
            h = held[0];
            chk("RDaddr_o", bus.RDaddr_o, h.rd);
            chk("ALU_result_o", bus.ALU_result_o, h.alu);
            chk("dataMem_data_o", bus.dataMem_data_o, h.mem);
            chk("MemtoReg_o", bus.MemtoReg_o, h.m2r);
            chk("RegWrite_o", bus.RegWrite_o, h.rw && h.rd != 0);
            chk("wb_data_o", bus.wb_data_o, h.m2r ? h.mem : h.alu);
        end else begin
            chk("RegWrite_o_idle", bus.RegWrite_o, 1'b0);
        end
        fl  = bus.flush_i;
        acc = bus.valid_i && er && !fl;
        drn = ev && bus.ready_i && !bus.stall_i;
        inp.rw  = bus.RegWrite_i;
        inp.m2r = bus.MemtoReg_i;
        inp.mem = bus.dataMem_data_i;
        inp.alu = bus.ALU_result_i;
        inp.rd  = bus.RDaddr_i;
        @(posedge clk);
        if (fl) begin
            held.delete();
        end else begin
            if (drn) void'(held.pop_front());
            if (acc) held.push_back(inp);
        end
        @(negedge clk);
    endtask

    // Offer an entry until the model says it was taken.
    task automatic offer(input logic rw, input logic m2r,
                         input logic [31:0] mem, input logic [31:0] alu,
                         input logic [4:0] rd);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        drive(1'b1, rw, m2r, mem, alu, rd);
        while (!acc && n < 10) begin
            cyc(acc);
            n++;
        end
        if (!acc) chk("offer_timeout", 64'd0, 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(acc);
    endtask

    initial begin
        bit acc;
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.ready_i = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'hAAAA5555, 32'h12345678, 5'd9);

        // Reset for two edges with valid_i high.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("rst_valid_o", bus.valid_o, 1'b0);
        chk("rst_ready_o", bus.ready_o, 1'b1);
        chk("rst_count_o", bus.count_o, 2'd0);
        chk("rst_RegWrite_o", bus.RegWrite_o, 1'b0);
        chk("rst_MemtoReg_o", bus.MemtoReg_o, 1'b0);
        chk("rst_mem_o", bus.dataMem_data_o, 32'h0);
        chk("rst_alu_o", bus.ALU_result_o, 32'h0);
        chk("rst_rd_o", bus.RDaddr_o, 5'd0);
        chk("rst_wb_o", bus.wb_data_o, 32'h0);
        idle(1);

        // Streaming, 1-cycle latency, ready_o stays high.
        bus.ready_i = 1'b1;
        offer(1'b1, 1'b0, 32'hF0, 32'h11, 5'd1);
        offer(1'b1, 1'b0, 32'hF1, 32'h22, 5'd2);
        offer(1'b1, 1'b0, 32'hF2, 32'h33, 5'd3);
        offer(1'b1, 1'b0, 32'hF3, 32'h44, 5'd4);
        idle(2);

        // Backpressure: fill main+skid, third held upstream.
        bus.ready_i = 1'b0;
        offer(1'b1, 1'b0, 32'h0, 32'hA1, 5'd5);
        offer(1'b0, 1'b0, 32'h0, 32'hA2, 5'd6);
        drive(1'b1, 1'b1, 1'b1, 32'hB3, 32'hA3, 5'd7);
        idle(2);
        bus.ready_i = 1'b1;
        offer(1'b1, 1'b1, 32'hB3, 32'hA3, 5'd7);
        idle(3);

        // Stall with ready_i=1 holding a memory-load entry.
        bus.ready_i = 1'b0;
        offer(1'b1, 1'b1, 32'hDEADBEEF, 32'h55, 5'd8);
        bus.stall_i = 1'b1;
        bus.ready_i = 1'b1;
        idle(3);
        chk("stall_wb_data", bus.wb_data_o, 32'hDEADBEEF);
        bus.stall_i = 1'b0;
        idle(2);

        // Zero-register write suppression, then a real write.
        offer(1'b1, 1'b0, 32'h0, 32'h66, 5'd0);
        chk("x0_RegWrite_o", bus.RegWrite_o, 1'b0);
        offer(1'b1, 1'b0, 32'h0, 32'h77, 5'd7);
        chk("x7_RegWrite_o", bus.RegWrite_o, 1'b1);
        idle(2);

        // Flush with two held entries and a live input.
        bus.ready_i = 1'b0;
        offer(1'b1, 1'b0, 32'h0, 32'hC1, 5'd10);
        offer(1'b1, 1'b0, 32'h0, 32'hC2, 5'd11);
        chk("pre_flush_count", bus.count_o, 2'd2);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'hC3, 5'd12);
        bus.flush_i = 1'b1;
        cyc(acc);
        bus.flush_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        chk("flush_valid_o", bus.valid_o, 1'b0);
        chk("flush_count_o", bus.count_o, 2'd0);
        chk("flush_ready_o", bus.ready_o, 1'b1);
        bus.ready_i = 1'b1;
        idle(3);

        // Flush coinciding with a drain empties the stage.
        offer(1'b1, 1'b0, 32'h0, 32'hD1, 5'd13);
        bus.flush_i = 1'b1;
        cyc(acc);
        bus.flush_i = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
